// File: rtl/de_regfile_scoreboard_pkg.sv
// Shared sizing defaults for the DE-stage register file and its scoreboard.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package de_regfile_scoreboard_pkg;

    localparam int DEF_DBITS     = 32;
    localparam int DEF_REGWORDS  = 32;
    localparam int DEF_REGNOBITS = 5;
    localparam int DEF_NUM_RD    = 2;
    localparam int DEF_NUM_WB    = 1;
    localparam int DEF_CNTBITS   = 2;

    // Width needed to count every writeback port plus the squash port
    // hitting the same register in one cycle.
    function automatic int dec_width(input int num_wb);
        return $clog2(num_wb + 2);
    endfunction

endpackage

// File: rtl/de_regfile_scoreboard_sb_counter.sv
// Pending-write counter for one register: +1 on issue, -N on retire/squash, saturating.
// Latency: new count visible the cycle after the update; underflow is combinational.
// Backpressure: none; the caller must avoid overflow (stall at max), underflow clamps to 0.
// Ports: clk, reset (async active-low), inc, dec (multi-count), cnt, underflow.
module de_regfile_scoreboard_sb_counter #(
    parameter int CNTBITS = 2,
    parameter int DECW    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic [DECW-1:0]    dec,
    output logic [CNTBITS-1:0] cnt,
    output logic               underflow
);

    // Two guard bits over the counter: one for headroom above the max, one as sign.
    localparam int AW = (CNTBITS + 2 > DECW + 1) ? CNTBITS + 2 : DECW + 1;

    logic [AW-1:0] sum;

    assign sum       = AW'(cnt) + AW'(inc) - AW'(dec);
    assign underflow = sum[AW-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (underflow) begin
            cnt <= '0;
        end else if (|sum[AW-2:CNTBITS]) begin
            cnt <= '1;
        end else begin
            cnt <= sum[CNTBITS-1:0];
        end
    end

endmodule

// File: rtl/de_regfile_scoreboard.sv
// DE-stage register file with per-register pending-write scoreboard and WB bypass.
// Latency: operands combinational (same-cycle WB bypass); scoreboard updates next cycle.
// Backpressure: stall holds decode on RAW hazards or a full pending counter.
// Ports: issue_* / rs_* from decode, rs_data/stall/issue_accept back; wb_* from WB;
//        squash_* from AGEX; busy_vec and sticky sb_err for observation.
module de_regfile_scoreboard
    import de_regfile_scoreboard_pkg::*;
#(
    parameter int DBITS     = DEF_DBITS,
    parameter int REGWORDS  = DEF_REGWORDS,
    parameter int REGNOBITS = DEF_REGNOBITS,
    parameter int NUM_RD    = DEF_NUM_RD,
    parameter int NUM_WB    = DEF_NUM_WB,
    parameter int CNTBITS   = DEF_CNTBITS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        issue_valid,
    input  logic [NUM_RD*REGNOBITS-1:0] rs_addr,
    input  logic [NUM_RD-1:0]           rs_use,
    input  logic                        issue_wr,
    input  logic [REGNOBITS-1:0]        issue_rd,
    output logic [NUM_RD*DBITS-1:0]     rs_data,
    output logic                        stall,
    output logic                        issue_accept,
    input  logic [NUM_WB-1:0]           wb_valid,
    input  logic [NUM_WB*REGNOBITS-1:0] wb_regno,
    input  logic [NUM_WB*DBITS-1:0]     wb_data,
    input  logic [NUM_WB-1:0]           wb_dec,
    input  logic                        squash_valid,
    input  logic [REGNOBITS-1:0]        squash_regno,
    output logic [REGWORDS-1:0]         busy_vec,
    output logic                        sb_err
);

    localparam int DECW = dec_width(NUM_WB);
    localparam logic [CNTBITS-1:0] CNT_MAX = '1;

    logic [DBITS-1:0]     regs      [REGWORDS];
    logic [CNTBITS-1:0]   cnt       [REGWORDS];
    logic [REGNOBITS-1:0] src_addr  [NUM_RD];
    logic [NUM_RD-1:0]    src_rdy;
    logic [REGWORDS-1:1]  inc_vec;
    logic [REGWORDS-1:1]  uflow_vec;
    logic [DECW-1:0]      dec_cnt   [1:REGWORDS-1];

    // r0 is hard-wired: never pending.
    assign cnt[0] = '0;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_src
        assign src_addr[i] = rs_addr[i*REGNOBITS +: REGNOBITS];
    end

    // Operand mux: register file value, overridden by a matching writeback.
    // Later ports overwrite earlier ones so the highest index wins.
    always_comb begin
        rs_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (src_addr[i] != '0) begin
                rs_data[i*DBITS +: DBITS] = regs[src_addr[i]];
                for (int j = 0; j < NUM_WB; j++) begin
                    if (wb_valid[j] && wb_regno[j*REGNOBITS +: REGNOBITS] == src_addr[i]) begin
                        rs_data[i*DBITS +: DBITS] = wb_data[j*DBITS +: DBITS];
                    end
                end
            end
        end
    end

    // A source with exactly one outstanding write is ready if that write
    // retires this cycle, since its value arrives through the bypass.
    always_comb begin
        src_rdy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            logic retire_hit;
            retire_hit = 1'b0;
            for (int j = 0; j < NUM_WB; j++) begin
                if (wb_valid[j] && wb_dec[j] &&
                    wb_regno[j*REGNOBITS +: REGNOBITS] == src_addr[i]) begin
                    retire_hit = 1'b1;
                end
            end
            src_rdy[i] = !rs_use[i] || (src_addr[i] == '0) || (cnt[src_addr[i]] == '0) ||
                         ((cnt[src_addr[i]] == CNTBITS'(1)) && retire_hit);
        end
    end

    // The full-counter check ignores same-cycle decrements on purpose: keeps
    // the stall path short at the cost of an occasional extra bubble.
    assign stall = issue_valid &&
                   (!(&src_rdy) ||
                    (issue_wr && issue_rd != '0 && cnt[issue_rd] == CNT_MAX));
    assign issue_accept = issue_valid && !stall;

    always_comb begin
        inc_vec = '0;
        for (int r = 1; r < REGWORDS; r++) begin
            inc_vec[r] = issue_accept && issue_wr && (issue_rd == REGNOBITS'(r));
            dec_cnt[r] = '0;
            for (int j = 0; j < NUM_WB; j++) begin
                if (wb_valid[j] && wb_dec[j] &&
                    wb_regno[j*REGNOBITS +: REGNOBITS] == REGNOBITS'(r)) begin
                    dec_cnt[r] = dec_cnt[r] + DECW'(1);
                end
            end
            if (squash_valid && squash_regno == REGNOBITS'(r)) begin
                dec_cnt[r] = dec_cnt[r] + DECW'(1);
            end
        end
    end

    for (genvar r = 1; r < REGWORDS; r++) begin : g_cnt
        de_regfile_scoreboard_sb_counter #(
            .CNTBITS (CNTBITS),
            .DECW    (DECW)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc_vec[r]),
            .dec       (dec_cnt[r]),
            .cnt       (cnt[r]),
            .underflow (uflow_vec[r])
        );
    end

    // Derived from counter state only, so an async reset clears it immediately.
    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < REGWORDS; r++) begin
            busy_vec[r] = (cnt[r] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_err <= 1'b0;
        end else if (|uflow_vec) begin
            sb_err <= 1'b1;
        end
    end

    // Writes in port order so the highest port wins a same-register collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < REGWORDS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WB; j++) begin
                if (wb_valid[j] && wb_regno[j*REGNOBITS +: REGNOBITS] != '0) begin
                    regs[wb_regno[j*REGNOBITS +: REGNOBITS]] <= wb_data[j*DBITS +: DBITS];
                end
            end
        end
    end

endmodule

// File: doc/de_regfile_scoreboard.md
Name: de_regfile_scoreboard

Overview:
- Parametrised successor to the DE-stage register file: multi-port architectural register file plus per-register pending-write scoreboard.
- Generates the DE-stage hazard stall and supplies operands with same-cycle writeback bypass.
- Supports NUM_RD read ports and NUM_WB writeback ports, plus a squash port that releases scoreboard entries for killed instructions.
- Sits in DE. Issue requests come from decode, writebacks from WB, squashes from AGEX on branch redirect.

Parameters:
- DBITS, 32, data width.
- REGWORDS, 32, number of architectural registers (power of 2).
- REGNOBITS, 5, log2(REGWORDS).
- NUM_RD, 2, operand read ports.
- NUM_WB, 1, writeback ports.
- CNTBITS, 2, pending-write counter width; CNT_MAX = 2^CNTBITS-1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; asserting it clears all state immediately.
- issue_valid  in  1  decode presents an instruction this cycle.
- rs_addr  in  NUM_RD*REGNOBITS  source register numbers; port i at slice i.
- rs_use  in  NUM_RD  source i is actually read.
- issue_wr  in  1  instruction writes a destination register.
- issue_rd  in  REGNOBITS  destination register number.
- rs_data  out  NUM_RD*DBITS  operand values, combinational.
- stall  out  1  hazard; decode must hold the instruction.
- issue_accept  out  1  equals issue_valid & ~stall.
- wb_valid  in  NUM_WB  writeback port j is active.
- wb_regno  in  NUM_WB*REGNOBITS  writeback destination.
- wb_data  in  NUM_WB*DBITS  writeback value.
- wb_dec  in  NUM_WB  writeback retires a scoreboarded write.
- squash_valid  in  1  release one pending entry without writing data.
- squash_regno  in  REGNOBITS  register to release.
- busy_vec  out  REGWORDS  bit r set when cnt[r] != 0, registered-state derived.
- sb_err  out  1  sticky flag: decrement of a zero counter, or write to a non-pending register with wb_dec set.

Behaviour:
Reset values:
- All regs = 0, all cnt = 0, sb_err = 0.
- busy_vec = 0 and stall = 0 while reset is asserted.

Register 0:
- Reads always return 0.
- Writes are ignored.
- Never scoreboarded: issue, wb and squash involving r0 have no counter effect.

Reads (combinational):
- rs_data[i] = matching wb_data when wb_valid[j] and wb_regno[j] == rs_addr[i] != 0 (same-cycle bypass).
- Otherwise rs_data[i] = regs[rs_addr[i]].
- If several wb ports match, the highest index j wins.

Writes (posedge):
- regs[wb_regno[j]] <= wb_data[j] for each valid j with wb_regno != 0.
- Same-register collision: highest j wins.

Source readiness:
- Source i is ready if ~rs_use[i], or rs_addr[i] == 0, or cnt == 0.
- It is also ready if cnt == 1 and some port j this cycle has wb_valid & wb_dec & matching regno.

Stall:
- stall = issue_valid & (any source not ready | (issue_wr & issue_rd != 0 & cnt[issue_rd] == CNT_MAX)).
- WAW hazards do not stall; they are counted.

Counter update per register r (posedge):
- cnt' = cnt + inc - dec.
- inc = issue_accept & issue_wr & issue_rd == r.
- dec = number of wb ports with wb_valid & wb_dec & regno == r, plus squash_valid & squash_regno == r.
- Arithmetic is done at CNTBITS+2 bits.
- Any result below 0 saturates to 0 and sets sb_err.
- Increment and decrement in the same cycle net out, so a full counter may accept a new issue only if it is also decremented. The stall equation stays conservative: it stalls at CNT_MAX regardless.

Latency:
- Scoreboard state is visible one cycle after issue.
- Writeback is bypassed in the same cycle.

Mid-operation reset: in-flight counts are lost. The pipeline is reset simultaneously by design.

Decomposition:
- Shared package / define.vh holds DBITS, REGNOBITS and REGWORDS (already present), plus CNTBITS, NUM_RD and NUM_WB defaults.
- One natural sub-module, sb_counter: a single saturating up/down counter with a multi-decrement input and an underflow flag, instantiated REGWORDS-1 times via generate.
- The read/bypass mux stays in the top module.

Test Plan:
- Reset release, read r5 and r0 -> rs_data = 0, stall = 0, busy_vec = 0.
- Issue wr r3 (accepted); next cycle issue reading r3 -> stall = 1. Then wb r3 = 0xDEADBEEF with wb_dec -> same cycle stall = 0, rs_data = 0xDEADBEEF; next cycle busy_vec[3] = 0, regs[3] = 0xDEADBEEF.
- Issue wr r7 three times (CNT_MAX = 3) -> cnt = 3; fourth issue wr r7 -> stall = 1. One wb_dec r7 -> cnt = 2, busy stays set.
- NUM_WB = 2: both ports write r4 (0x11, 0x22) with wb_dec, cnt[4] = 2 -> regs[4] = 0x22, cnt = 0, bypass returns 0x22.
- squash r9 with cnt = 1 -> cnt = 0, regs[9] unchanged. Then squash r9 again -> cnt stays 0, sb_err = 1 and remains sticky.
- Issue wr r0 and wb r0 = 0x5 -> no busy, r0 reads 0. Assert reset mid-flight with cnt[2] = 2 -> busy_vec = 0 immediately, asynchronously.
